// File: rtl/threebit_accum_pkg.sv
// Shared types and defaults for the threebit packet accumulator.
package threebit_pkg;

   localparam int W_DEF     = 3;
   localparam int CNT_W_DEF = 4;

   // IDLE: no packet in progress, ACC: packet partially summed, HOLD: result presented
   typedef enum logic [1:0] {IDLE, ACC, HOLD} accum_state_t;

endpackage

// File: rtl/threebit_accum_if.sv
// Operand stream in, packet result out.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
// valid must not wait on ready, and ready never depends on valid.
interface threebit_accum_if import threebit_pkg::*; #(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   // upstream producer / downstream consumer side
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );

   // accumulator side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/threebit_accum_ripple.sv
// W chained full adders; identical to the existing 3-bit ripple adder when W=3.
module accum_ripple #(
   parameter int W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W:0] c;

   assign c[0] = cin;

   // one full adder per bit, carry rippling upward
   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[W];
endmodule

// File: rtl/threebit_accum.sv
// Packet accumulator: folds operands into a running sum, presents {sum, ovf, count}
// per packet on a valid/ready result port, with zero-bubble back-to-back packets.
module threebit_accum import threebit_pkg::*; #(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sync_clr,
   threebit_accum_if.slave        bus,
   output accum_state_t           dbg_state
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   accum_state_t     state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [W-1:0]     sum_w;
   logic             cout_w;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;

   accum_ripple #(.W(W)) u_add (
      .a    (acc_q),
      .b    (bus.in_data),
      .cin  (1'b0),
      .s    (sum_w),
      .cout (cout_w)
   );

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // handshake decode and next-state; a pop coinciding with an accept starts a new packet
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      out_valid_c = (state_q == HOLD);
      in_ready_c  = !sync_clr && (!out_valid_c || bus.out_ready);
      accept      = bus.in_valid && in_ready_c;

      if (sync_clr) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (accept) begin
                  acc_d   = bus.in_data;
                  ovf_d   = 1'b0;
                  cnt_d   = CNT_ONE;
                  state_d = bus.in_last ? HOLD : ACC;
               end else if (out_valid_c && bus.out_ready) begin
                  state_d = IDLE;
               end
            end
            ACC: begin
               if (accept) begin
                  acc_d   = sum_w;
                  ovf_d   = ovf_q | cout_w;
                  cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                  state_d = bus.in_last ? HOLD : ACC;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_count = cnt_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_threebit_accum.sv
// Bench for threebit_accum: directed packets, packet-level model, per-cycle compare.
module tb_threebit_accum;
   import threebit_pkg::*;

   localparam int W     = 3;
   localparam int CNT_W = 4;
   localparam int MOD   = 1 << W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic sync_clr;
   accum_state_t dbg_state;

   always #5 clk = ~clk;

   threebit_accum_if #(.W(W), .CNT_W(CNT_W)) bus ();

   threebit_accum #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_clr  (sync_clr),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- packet-level model ----------------
   // m_active: a packet has begun but its last operand is not yet in
   // m_hold:   a finished packet result is waiting to be taken
   logic m_hold   = 1'b0;
   logic m_active = 1'b0;
   int   m_run    = 0;
   logic m_ovf    = 1'b0;
   int   m_n      = 0;
   int   r_sum    = 0;
   logic r_ovf    = 1'b0;
   int   r_cnt    = 0;

   always @(posedge clk or negedge rst_n) begin : model
      int   run, n;
      logic ovf, hold, active, rdy;
      if (!rst_n) begin
         m_hold   <= 1'b0;
         m_active <= 1'b0;
         m_run    <= 0;
         m_ovf    <= 1'b0;
         m_n      <= 0;
      end else if (sync_clr) begin
         m_hold   <= 1'b0;
         m_active <= 1'b0;
      end else begin
         run    = m_run;
         n      = m_n;
         ovf    = m_ovf;
         hold   = m_hold;
         active = m_active;
         rdy    = !hold || bus.out_ready;
         if (hold && bus.out_ready) hold = 1'b0;
         if (bus.in_valid && rdy) begin
            if (!active) begin
               run    = 0;
               ovf    = 1'b0;
               n      = 0;
               active = 1'b1;
            end
            run = run + int'(bus.in_data);
            if (run >= MOD) begin
               ovf = 1'b1;
               run = run - MOD;
            end
            n = (n < CMAX) ? n + 1 : CMAX;
            if (bus.in_last) begin
               r_sum  <= run;
               r_ovf  <= ovf;
               r_cnt  <= n;
               hold   = 1'b1;
               active = 1'b0;
            end
         end
         m_run    <= run;
         m_n      <= n;
         m_ovf    <= ovf;
         m_hold   <= hold;
         m_active <= active;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      accum_state_t exp_st;
      logic         exp_rdy;
      exp_st  = m_hold ? HOLD : (m_active ? ACC : IDLE);
      exp_rdy = !sync_clr && (!m_hold || bus.out_ready);
      chk("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      chk("cyc_out_valid", {31'b0, bus.out_valid}, {31'b0, m_hold});
      chk("cyc_state", {30'b0, dbg_state}, {30'b0, exp_st});
      if (m_hold) begin
         chk("cyc_sum", {29'b0, bus.out_sum}, r_sum);
         chk("cyc_ovf", {31'b0, bus.out_ovf}, {31'b0, r_ovf});
         chk("cyc_count", {28'b0, bus.out_count}, r_cnt);
      end
   end

   // ---------------- driver tasks ----------------
   // Present one operand and hold it until accepted; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic last);
      int k;
      k = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("send_timeout", k, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Wait (bounded) for a result and pin it against hand-computed values.
   task automatic wait_result(input string tag, input int es, input int eo, input int ec);
      int k;
      k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_valid"}, {31'b0, bus.out_valid}, 1);
      chk({tag, "_latency"}, k, 0);
      chk({tag, "_sum"}, {29'b0, bus.out_sum}, es);
      chk({tag, "_ovf"}, {31'b0, bus.out_ovf}, eo);
      chk({tag, "_count"}, {28'b0, bus.out_count}, ec);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] b2b_vals [4] = '{3'd1, 3'd6, 3'd2, 3'd7};

   initial begin
      rst_n         = 1'b0;
      sync_clr      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_sum", {29'b0, bus.out_sum}, 0);
      chk("rst_ovf", {31'b0, bus.out_ovf}, 0);
      chk("rst_count", {28'b0, bus.out_count}, 0);
      chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: 3 + 4
      bus.out_ready = 1'b1;
      send(3'd3, 1'b0);
      send(3'd4, 1'b1);
      wait_result("t1", 7, 0, 2);
      @(posedge clk);
      #1;

      // 2: 5 + 6 wraps to 3 with carry
      send(3'd5, 1'b0);
      send(3'd6, 1'b1);
      wait_result("t2", 3, 1, 2);
      @(posedge clk);
      #1;

      // 3: single 7, held under backpressure, then pop + accept in the same cycle
      bus.out_ready = 1'b0;
      send(3'd7, 1'b1);
      wait_result("t3a", 7, 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 3'd2;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_ready", {31'b0, bus.in_ready}, 0);
         chk("t3_stall_sum", {29'b0, bus.out_sum}, 7);
         chk("t3_stall_count", {28'b0, bus.out_count}, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      wait_result("t3b", 2, 0, 1);
      @(posedge clk);
      #1;

      // 4: seventeen 1s -> sum 1, carry seen, count saturated
      for (int i = 1; i <= 17; i++) send(3'd1, (i == 17));
      wait_result("t4", 1, 1, 15);
      @(posedge clk);
      #1;

      // 5: async reset in the middle of a packet
      send(3'd1, 1'b0);
      send(3'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", {31'b0, bus.out_valid}, 0);
      chk("t5_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(3'd1, 1'b1);
      wait_result("t5", 1, 0, 1);
      @(posedge clk);
      #1;

      // 6: sync_clr while a result is held; offered operand must not be consumed
      bus.out_ready = 1'b0;
      send(3'd3, 1'b1);
      wait_result("t6a", 3, 0, 1);
      @(posedge clk);
      #1;
      sync_clr     = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 3'd5;
      bus.in_last  = 1'b1;
      #1;
      chk("t6_clr_ready", {31'b0, bus.in_ready}, 0);
      chk("t6_clr_valid_same", {31'b0, bus.out_valid}, 1);
      @(posedge clk);
      #1;
      sync_clr     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("t6_valid_after", {31'b0, bus.out_valid}, 0);
      chk("t6_state_after", {30'b0, dbg_state}, {30'b0, IDLE});
      bus.out_ready = 1'b1;
      send(3'd2, 1'b1);
      wait_result("t6b", 2, 0, 1);
      @(posedge clk);
      #1;

      // 7: back-to-back single-operand packets, no bubbles
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = b2b_vals[i];
         @(posedge clk);
         #1;
         chk("t7_valid", {31'b0, bus.out_valid}, 1);
         chk("t7_sum", {29'b0, bus.out_sum}, {29'b0, b2b_vals[i]});
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
